// File: rtl/packet_gen_pkg.sv
// packet_gen_pkg: shared types and helpers for the packet generator.
//   desc_t    - 32-bit packet descriptor layout as written by software
//   state_t   - per-port framing FSM states
//   build_hdr - header word {dest, len, seq, tag}
//   build_pay - payload word {tag, 10'b0, index}
package packet_gen_pkg;

  localparam int DEST_W = 2;
  localparam int LEN_W  = 6;
  localparam int RSVD_W = 8;
  localparam int TAG_W  = 16;
  localparam int SEQ_W  = 8;
  localparam int DROP_W = 8;
  localparam int WORD_W = DEST_W + LEN_W + RSVD_W + TAG_W;

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [LEN_W-1:0]  len;
    logic [RSVD_W-1:0] rsvd;
    logic [TAG_W-1:0]  tag;
  } desc_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } state_t;

  // The reserved byte of the descriptor is replaced by the running sequence.
  function automatic logic [WORD_W-1:0] build_hdr(input desc_t d, input logic [SEQ_W-1:0] seq);
    return {d.dest, d.len, seq, d.tag};
  endfunction

  function automatic logic [WORD_W-1:0] build_pay(input desc_t d, input logic [LEN_W-1:0] idx);
    return {d.tag, 10'b0, idx};
  endfunction

endpackage

// File: rtl/packet_gen_fifo.sv
// desc_fifo: synchronous descriptor FIFO, no fall-through.
//   clk, rst_n   - clock, asynchronous active-low reset
//   push, wdata  - write strobe and word; ignored when full unless popping
//   pop, rdata   - read strobe and head word (rdata valid while !empty)
//   full, empty  - occupancy flags
//   count        - number of stored entries, 0..DEPTH
module desc_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [DW-1:0]          wdata,
  input  logic                   pop,
  output logic [DW-1:0]          rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign rdata = mem[rd_ptr];

  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/packet_gen.sv
// packet_gen: per-port descriptor queues expanded into framed word streams.
//   clk, reset_n      - clock, asynchronous active-low reset
//   interface_out_en  - per-port descriptor write strobe
//   interface_out     - descriptor word {dest, len, rsvd, tag}
//   pkt_valid/ready   - per-port stream handshake
//   pkt_data          - per-port stream word, port p at [p*DW +: DW]
//   pkt_sop/pkt_eop   - header-word and last-word markers
//   busy              - port framing a packet or holding queued descriptors
//   drop_cnt          - per-port saturating count of descriptors lost to a full FIFO
module packet_gen
  import packet_gen_pkg::*;
#(
  parameter int NPORTS = 4,
  parameter int DEPTH  = 4,
  parameter int DW     = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NPORTS-1:0]        interface_out_en,
  input  logic [DW-1:0]            interface_out,
  output logic [NPORTS-1:0]        pkt_valid,
  output logic [NPORTS*DW-1:0]     pkt_data,
  output logic [NPORTS-1:0]        pkt_sop,
  output logic [NPORTS-1:0]        pkt_eop,
  input  logic [NPORTS-1:0]        pkt_ready,
  output logic [NPORTS-1:0]        busy,
  output logic [NPORTS*DROP_W-1:0] drop_cnt
);

  // Reset asserts immediately but is released on a clock edge, two flops deep.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  for (genvar p = 0; p < NPORTS; p++) begin : g_port

    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DW-1:0]          fifo_rdata;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   drop;
    state_t                 state_q, state_d;
    desc_t                  desc_q, desc_d;
    logic [SEQ_W-1:0]       seq_q, seq_d;
    logic [LEN_W-1:0]       idx_q, idx_d;
    logic [DROP_W-1:0]      drops_q;
    logic                   valid, sop, eop;
    logic [DW-1:0]          data;

    desc_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (interface_out_en[p]),
      .wdata (interface_out),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
    );

    // Matches the FIFO's own acceptance rule: full and the head is not leaving.
    assign drop = interface_out_en[p] && fifo_full && !fifo_pop;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        desc_q  <= '0;
        seq_q   <= '0;
        idx_q   <= '0;
        drops_q <= '0;
      end else begin
        state_q <= state_d;
        desc_q  <= desc_d;
        seq_q   <= seq_d;
        idx_q   <= idx_d;
        if (drop && (drops_q != '1)) drops_q <= drops_q + 1'b1;
      end
    end

    // Stream outputs come straight from registered state, so they hold
    // stable for as long as ready stays low.
    always_comb begin
      state_d  = state_q;
      desc_d   = desc_q;
      seq_d    = seq_q;
      idx_d    = idx_q;
      fifo_pop = 1'b0;
      valid    = 1'b0;
      sop      = 1'b0;
      eop      = 1'b0;
      data     = '0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            desc_d   = desc_t'(fifo_rdata);
            state_d  = ST_HDR;
          end
        end
        ST_HDR: begin
          valid = 1'b1;
          sop   = 1'b1;
          eop   = (desc_q.len == '0);
          data  = build_hdr(desc_q, seq_q);
          if (pkt_ready[p]) begin
            seq_d = seq_q + 1'b1;
            if (desc_q.len == '0) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_PAY;
              idx_d   = LEN_W'(1);
            end
          end
        end
        ST_PAY: begin
          valid = 1'b1;
          eop   = (idx_q == desc_q.len);
          data  = build_pay(desc_q, idx_q);
          if (pkt_ready[p]) begin
            if (idx_q == desc_q.len) state_d = ST_IDLE;
            else                     idx_d   = idx_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    assign pkt_valid[p]                 = valid;
    assign pkt_sop[p]                   = sop;
    assign pkt_eop[p]                   = eop;
    assign pkt_data[p*DW +: DW]         = data;
    assign busy[p]                      = (state_q != ST_IDLE) || (fifo_count != '0);
    assign drop_cnt[p*DROP_W +: DROP_W] = drops_q;

  end

endmodule

// File: tb/tb_packet_gen.sv
// tb_packet_gen: directed self-checking bench for packet_gen.
module tb_packet_gen;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   en;
  logic [31:0]  din;
  logic [3:0]   ready;
  logic [3:0]   pkt_valid;
  logic [127:0] pkt_data;
  logic [3:0]   pkt_sop;
  logic [3:0]   pkt_eop;
  logic [3:0]   busy;
  logic [31:0]  drop_cnt;

  packet_gen #(.NPORTS(4), .DEPTH(4), .DW(32)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .interface_out_en (en),
    .interface_out    (din),
    .pkt_valid        (pkt_valid),
    .pkt_data         (pkt_data),
    .pkt_sop          (pkt_sop),
    .pkt_eop          (pkt_eop),
    .pkt_ready        (ready),
    .busy             (busy),
    .drop_cnt         (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Expected stream words per port, each {sop, eop, data}.
  logic [33:0] exp_q [4][$];
  logic [7:0]  seq_m [4];
  logic        mon_on = 1'b0;
  logic [3:0]  held = '0;
  logic [33:0] held_word [4];
  logic [31:0] d1 [6];

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Reference expansion of one descriptor into its framed words.
  task automatic expect_packet(input int p, input logic [31:0] d);
    logic [5:0] len;
    len = d[29:24];
    exp_q[p].push_back({1'b1, (len == 6'd0), d[31:30], len, seq_m[p], d[15:0]});
    for (int i = 1; i <= int'(len); i++)
      exp_q[p].push_back({1'b0, (i == int'(len)), d[15:0], 10'b0, 6'(i)});
    seq_m[p] = seq_m[p] + 8'd1;
  endtask

  // One-cycle descriptor write; the push happens at the second posedge.
  task automatic applyStimulus(input logic [3:0] mask, input logic [31:0] word);
    @(posedge clk); #1;
    en  = mask;
    din = word;
    @(posedge clk); #1;
    en  = '0;
  endtask

  task automatic drain(input int p, input int max_cycles);
    int n;
    n = 0;
    while (exp_q[p].size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput($sformatf("drain_p%0d", p), exp_q[p].size(), 0);
    @(negedge clk);
    checkOutput($sformatf("idle_after_drain_p%0d", p), busy[p], 0);
  endtask

  // Scoreboard: every transferred word must match the model, and a stalled
  // word must be unchanged one cycle later.
  always @(negedge clk) begin
    if (!mon_on) begin
      held = '0;
    end else begin
      for (int p = 0; p < 4; p++) begin
        logic [33:0] cur;
        cur = {pkt_sop[p], pkt_eop[p], pkt_data[p*32 +: 32]};
        if (held[p])
          checkOutput($sformatf("hold_p%0d", p), {pkt_valid[p], cur}, {1'b1, held_word[p]});
        if (pkt_valid[p] && ready[p]) begin
          checkOutput($sformatf("word_pending_p%0d", p), (exp_q[p].size() != 0), 1);
          if (exp_q[p].size() != 0)
            checkOutput($sformatf("stream_p%0d", p), cur, exp_q[p].pop_front());
        end
        held[p]      = pkt_valid[p] && !ready[p];
        held_word[p] = cur;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time %0t reached, limit 2000000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    en      = '0;
    din     = '0;
    ready   = 4'hF;
    for (int p = 0; p < 4; p++) seq_m[p] = 8'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", pkt_valid, 0);
    checkOutput("rst_data", pkt_data, 0);
    checkOutput("rst_sop", pkt_sop, 0);
    checkOutput("rst_eop", pkt_eop, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_drop", drop_cnt, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    mon_on = 1'b1;

    // Port 0: len 3 packet with exact timing
    expect_packet(0, 32'h4300_1234);
    applyStimulus(4'b0001, 32'h4300_1234);
    @(negedge clk);
    checkOutput("p0_pop_gap", pkt_valid[0], 0);
    @(negedge clk);
    checkOutput("p0_hdr", {pkt_valid[0], pkt_sop[0], pkt_eop[0], pkt_data[31:0]}, {3'b110, 32'h4300_1234});
    @(negedge clk);
    checkOutput("p0_pay1", {pkt_valid[0], pkt_sop[0], pkt_eop[0], pkt_data[31:0]}, {3'b100, 32'h1234_0001});
    @(negedge clk);
    checkOutput("p0_pay2", {pkt_valid[0], pkt_sop[0], pkt_eop[0], pkt_data[31:0]}, {3'b100, 32'h1234_0002});
    @(negedge clk);
    checkOutput("p0_pay3", {pkt_valid[0], pkt_sop[0], pkt_eop[0], pkt_data[31:0]}, {3'b101, 32'h1234_0003});
    @(negedge clk);
    checkOutput("p0_after_eop", pkt_valid[0], 0);

    // Port 2: zero-length packets, seq advance, reserved byte ignored
    expect_packet(2, 32'h8000_BEEF);
    applyStimulus(4'b0100, 32'h8000_BEEF);
    @(negedge clk);
    @(negedge clk);
    checkOutput("p2_len0", {pkt_valid[2], pkt_sop[2], pkt_eop[2], pkt_data[95:64]}, {3'b111, 32'h8000_BEEF});
    expect_packet(2, 32'h80FF_0005);
    applyStimulus(4'b0100, 32'h80FF_0005);
    @(negedge clk);
    @(negedge clk);
    checkOutput("p2_seq1", {pkt_valid[2], pkt_sop[2], pkt_eop[2], pkt_data[95:64]}, {3'b111, 32'h8001_0005});

    // Port 1: stalled, six writes, one dropped
    d1[0] = 32'h0100_0010; d1[1] = 32'h0000_0011; d1[2] = 32'h0200_0012;
    d1[3] = 32'h0000_0013; d1[4] = 32'h0100_0014; d1[5] = 32'h0000_0015;
    for (int i = 0; i < 5; i++) expect_packet(1, d1[i]);
    @(posedge clk); #1;
    ready[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      en  = 4'b0010;
      din = d1[i];
      @(posedge clk); #1;
    end
    en = '0;
    @(negedge clk);
    checkOutput("p1_drop", drop_cnt[15:8], 1);
    checkOutput("p1_hdr_stalled", {pkt_valid[1], pkt_sop[1], pkt_eop[1], pkt_data[63:32]}, {3'b110, 32'h0100_0010});
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    ready[1] = 1'b1;
    drain(1, 100);

    // Port 0: full FIFO with simultaneous pop and push
    for (int i = 0; i < 6; i++) expect_packet(0, 32'h0000_0020 + i);
    @(posedge clk); #1;
    ready[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      en  = 4'b0001;
      din = 32'h0000_0020 + i;
      @(posedge clk); #1;
    end
    en       = '0;
    ready[0] = 1'b1;
    @(posedge clk); #1;
    ready[0] = 1'b0;
    en       = 4'b0001;
    din      = 32'h0000_0025;
    @(posedge clk); #1;
    en = '0;
    @(negedge clk);
    checkOutput("p0_full_pushpop_nodrop", drop_cnt[7:0], 0);
    checkOutput("p0_hdr_e1", {pkt_valid[0], pkt_sop[0], pkt_eop[0], pkt_data[31:0]}, {3'b111, 32'h0002_0021});
    @(posedge clk); #1;
    en  = 4'b0001;
    din = 32'h0000_0027;
    @(posedge clk); #1;
    en = '0;
    @(negedge clk);
    checkOutput("p0_still_full_drop", drop_cnt[7:0], 1);
    @(posedge clk); #1;
    ready[0] = 1'b1;
    drain(0, 100);

    // Port 3: hammer until drop count saturates
    for (int i = 0; i < 5; i++) expect_packet(3, 32'h0000_0300 + i);
    @(posedge clk); #1;
    ready[3] = 1'b0;
    for (int i = 0; i < 300; i++) begin
      en  = 4'b1000;
      din = 32'h0000_0300 + i;
      @(posedge clk); #1;
    end
    en = '0;
    @(negedge clk);
    checkOutput("p3_drop_saturated", drop_cnt[31:24], 255);
    @(posedge clk); #1;
    ready[3] = 1'b1;
    drain(3, 100);

    // All ports concurrently with random ready
    for (int p = 0; p < 4; p++) expect_packet(p, 32'hC300_00AA);
    for (int i = 0; i < 3; i++)
      for (int p = 0; p < 4; p++)
        expect_packet(p, {2'(p), 6'(p + i), 8'h5A, 16'(16'hA000 + p * 16 + i)});
    @(posedge clk); #1;
    en    = 4'hF;
    din   = 32'hC300_00AA;
    ready = 4'($urandom_range(0, 15));
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < 4; p++) begin
        en    = 4'(1 << p);
        din   = {2'(p), 6'(p + i), 8'h5A, 16'(16'hA000 + p * 16 + i)};
        ready = 4'($urandom_range(0, 15));
        @(posedge clk); #1;
      end
    end
    en = '0;
    for (int n = 0; n < 3000; n++) begin
      if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() == 0) break;
      ready = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
    end
    ready = 4'hF;
    repeat (2) @(negedge clk);
    for (int p = 0; p < 4; p++)
      checkOutput($sformatf("concurrent_drain_p%0d", p), exp_q[p].size(), 0);
    checkOutput("concurrent_busy", busy, 0);
    checkOutput("drop_totals", drop_cnt, 32'hFF00_0101);

    // Reset mid-payload
    expect_packet(0, 32'h0A00_0099);
    @(posedge clk); #1;
    ready[1] = 1'b0;
    applyStimulus(4'b0011, 32'h0A00_0099);
    applyStimulus(4'b0010, 32'h0000_0001);
    @(negedge clk);
    checkOutput("p0_mid_payload", {pkt_valid[0], pkt_sop[0], pkt_eop[0], pkt_data[31:0]}, {3'b100, 32'h0099_0001});
    mon_on = 1'b0;
    for (int p = 0; p < 4; p++) begin
      exp_q[p].delete();
      seq_m[p] = 8'd0;
    end
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_valid", pkt_valid, 0);
    checkOutput("midrst_data", pkt_data, 0);
    checkOutput("midrst_sop_eop", {pkt_sop, pkt_eop}, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_drop", drop_cnt, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    ready   = 4'hF;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("post_rst_busy", busy, 0);
    checkOutput("post_rst_valid", pkt_valid, 0);
    mon_on = 1'b1;
    expect_packet(0, 32'h0000_0077);
    applyStimulus(4'b0001, 32'h0000_0077);
    @(negedge clk);
    @(negedge clk);
    checkOutput("post_rst_seq0", {pkt_valid[0], pkt_sop[0], pkt_eop[0], pkt_data[31:0]}, {3'b111, 32'h0000_0077});
    drain(0, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
